// File: rtl/read_addr_arbiter.sv
// read_addr_arbiter: round-robin arbiter for two AXI AR channels onto one shared
// read-address path. The grant is held from the AR handshake until the final R beat
// of the granted burst, and the owner flags steer R beats back to the right master.

`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module read_addr_arbiter (
   input  logic                       ACLK,
   input  logic                       ARESET,
   // master 0
   input  logic [`AXI_ID_BITS-1:0]    ARID_M0,
   input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M0,
   input  logic [`AXI_LEN_BITS-1:0]   ARLEN_M0,
   input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M0,
   input  logic [1:0]                 ARBURST_M0,
   input  logic                       ARVALID_M0,
   output logic                       ARREADY_M0,
   // master 1
   input  logic [`AXI_ID_BITS-1:0]    ARID_M1,
   input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M1,
   input  logic [`AXI_LEN_BITS-1:0]   ARLEN_M1,
   input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M1,
   input  logic [1:0]                 ARBURST_M1,
   input  logic                       ARVALID_M1,
   output logic                       ARREADY_M1,
   // shared slave-side AR path
   output logic [`AXI_IDS_BITS-1:0]   ARID_ARB,
   output logic [`AXI_ADDR_BITS-1:0]  ARADDR_ARB,
   output logic [`AXI_LEN_BITS-1:0]   ARLEN_ARB,
   output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_ARB,
   output logic [1:0]                 ARBURST_ARB,
   output logic                       ARVALID_ARB,
   input  logic                       ARREADY_ARB,
   // monitored shared R channel
   input  logic                       RVALID_ARB,
   input  logic                       RREADY_ARB,
   input  logic                       RLAST_ARB,
   // ownership and error status
   output logic                       M0_flag,
   output logic                       M1_flag,
   output logic                       RLAST_ERR
);

   localparam int unsigned IdPad = `AXI_IDS_BITS - `AXI_ID_BITS;
   localparam logic [`AXI_LEN_BITS-1:0] LenOne = `AXI_LEN_BITS'(1);

   typedef enum logic [2:0] {
      StIdle,
      StArM0,
      StArM1,
      StRM0,
      StRM1
   } state_e;

   state_e                      state_q;
   logic                        last_q;      // 1: master 1 was granted most recently
   logic [`AXI_IDS_BITS-1:0]    id_q;
   logic [`AXI_ADDR_BITS-1:0]   addr_q;
   logic [`AXI_LEN_BITS-1:0]    len_q;
   logic [`AXI_SIZE_BITS-1:0]   size_q;
   logic [1:0]                  burst_q;
   logic [`AXI_LEN_BITS-1:0]    beat_cnt_q;
   logic                        rlast_err_q;

   logic                        grant_m1;
   logic                        win_valid;
   logic [`AXI_IDS_BITS-1:0]    win_id;
   logic [`AXI_ADDR_BITS-1:0]   win_addr;
   logic [`AXI_LEN_BITS-1:0]    win_len;
   logic [`AXI_SIZE_BITS-1:0]   win_size;
   logic [1:0]                  win_burst;
   logic                        r_beat;
   logic                        cnt_at_len;

   // Round-robin winner; with both or neither requesting, the pointer favours the other master
   always_comb begin
      grant_m1 = ~last_q;
      if (ARVALID_M0 && ARVALID_M1) begin
         grant_m1 = ~last_q;
      end else if (ARVALID_M1) begin
         grant_m1 = 1'b1;
      end else if (ARVALID_M0) begin
         grant_m1 = 1'b0;
      end
   end

   // Winner's request fields; the ID is tagged into the owning master's nibble
   always_comb begin
      if (grant_m1) begin
         win_valid = ARVALID_M1;
         win_id    = {ARID_M1, {IdPad{1'b0}}};
         win_addr  = ARADDR_M1;
         win_len   = ARLEN_M1;
         win_size  = ARSIZE_M1;
         win_burst = ARBURST_M1;
      end else begin
         win_valid = ARVALID_M0;
         win_id    = {{IdPad{1'b0}}, ARID_M0};
         win_addr  = ARADDR_M0;
         win_len   = ARLEN_M0;
         win_size  = ARSIZE_M0;
         win_burst = ARBURST_M0;
      end
   end

   assign r_beat     = RVALID_ARB && RREADY_ARB;
   assign cnt_at_len = (beat_cnt_q == len_q);

   // Grant FSM, AR buffer, beat counter and sticky RLAST check
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= StIdle;
         last_q      <= 1'b1;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         beat_cnt_q  <= '0;
         rlast_err_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (win_valid) begin
                  state_q    <= grant_m1 ? StArM1 : StArM0;
                  id_q       <= win_id;
                  addr_q     <= win_addr;
                  len_q      <= win_len;
                  size_q     <= win_size;
                  burst_q    <= win_burst;
                  beat_cnt_q <= '0;
               end
            end
            StArM0: begin
               if (ARREADY_ARB) begin
                  state_q <= StRM0;
               end
            end
            StArM1: begin
               if (ARREADY_ARB) begin
                  state_q <= StRM1;
               end
            end
            StRM0, StRM1: begin
               if (r_beat) begin
                  // counter saturates at the requested length
                  if (!cnt_at_len) begin
                     beat_cnt_q <= beat_cnt_q + LenOne;
                  end
                  // last indication must coincide exactly with the final counted beat
                  if (RLAST_ARB != cnt_at_len) begin
                     rlast_err_q <= 1'b1;
                  end
                  if (RLAST_ARB) begin
                     state_q <= StIdle;
                     last_q  <= (state_q == StRM1);
                  end
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign ARREADY_M0  = (state_q == StIdle) && !grant_m1;
   assign ARREADY_M1  = (state_q == StIdle) && grant_m1;
   assign ARVALID_ARB = (state_q == StArM0) || (state_q == StArM1);
   assign M0_flag     = (state_q == StArM0) || (state_q == StRM0);
   assign M1_flag     = (state_q == StArM1) || (state_q == StRM1);
   assign RLAST_ERR   = rlast_err_q;

   assign ARID_ARB    = id_q;
   assign ARADDR_ARB  = addr_q;
   assign ARLEN_ARB   = len_q;
   assign ARSIZE_ARB  = size_q;
   assign ARBURST_ARB = burst_q;

endmodule
